// File: rtl/exec_writeback_unit_pkg.sv
// rtl/exec_writeback_unit_pkg.sv - shared control encodings, FSM states and control bundle for the execute/write-back unit
package exec_writeback_unit_pkg;

  localparam int ALU_OP_WIDTH = 4;

  typedef enum logic [ALU_OP_WIDTH-1:0] {
    OP_SUB = 4'h0,
    OP_AND = 4'h1,
    OP_OR  = 4'h3,
    OP_ADD = 4'h7
  } Alu_Operation_t;

  typedef enum logic {
    ALU_SRC_REG = 1'b0,
    ALU_SRC_IMM = 1'b1
  } Alu_Src_t;

  typedef enum logic {
    REG_SRC_MEM = 1'b0,
    REG_SRC_ALU = 1'b1
  } Reg_Data_Src_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    EXEC  = 3'd1,
    MREQ  = 3'd2,
    MWAIT = 3'd3,
    WB    = 3'd4
  } Exec_State_t;

  typedef struct packed {
    Alu_Operation_t alu_op;
    Alu_Src_t       alu_src;
    Reg_Data_Src_t  reg_src;
    logic           reg_write;
  } Exec_Ctrl_t;

endpackage

// File: rtl/exec_writeback_unit_if.sv
// rtl/exec_writeback_unit_if.sv - instruction, load and write-back bundle; illegal_op present with EXEC_ILLEGAL_OP_TRAP_EN
interface exec_writeback_unit_if #(
  parameter int DATA_WIDTH     = 64,
  parameter int REG_ADDR_WIDTH = 5
);

  // Decoded instruction from the control unit / register file read
  logic                      in_valid;
  logic                      in_ready;
  logic [3:0]                alu_op;
  logic                      alu_src;
  logic                      reg_src;
  logic                      reg_write;
  logic [REG_ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0]     rs1_data;
  logic [DATA_WIDTH-1:0]     rs2_data;
  logic [DATA_WIDTH-1:0]     imm;

  // Data-memory load port
  logic                      mem_req_valid;
  logic                      mem_req_ready;
  logic [DATA_WIDTH-1:0]     mem_addr;
  logic                      mem_rsp_valid;
  logic [DATA_WIDTH-1:0]     mem_rsp_data;

  // Register-file write port
  logic                      wb_valid;
  logic                      wb_we;
  logic [REG_ADDR_WIDTH-1:0] wb_rd;
  logic [DATA_WIDTH-1:0]     wb_data;
`ifdef EXEC_ILLEGAL_OP_TRAP_EN
  logic                      illegal_op;
`endif

  modport slave (
    input  in_valid, alu_op, alu_src, reg_src, reg_write, rd_addr, rs1_data, rs2_data, imm,
    output in_ready,
    output mem_req_valid, mem_addr,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data,
    output wb_valid, wb_we, wb_rd, wb_data
`ifdef EXEC_ILLEGAL_OP_TRAP_EN
    , output illegal_op
`endif
  );

  modport master (
    output in_valid, alu_op, alu_src, reg_src, reg_write, rd_addr, rs1_data, rs2_data, imm,
    input  in_ready,
    input  mem_req_valid, mem_addr,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data,
    input  wb_valid, wb_we, wb_rd, wb_data
`ifdef EXEC_ILLEGAL_OP_TRAP_EN
    , input illegal_op
`endif
  );

endinterface

// File: rtl/exec_writeback_unit_alu_core.sv
// rtl/exec_writeback_unit_alu_core.sv - combinational ALU: ADD/SUB wrap, AND/OR bitwise, undefined ops give 0 and flag illegal
module alu_core
  import exec_writeback_unit_pkg::*;
#(
  parameter int DATA_WIDTH = 64
) (
  input  logic [ALU_OP_WIDTH-1:0] op,
  input  logic [DATA_WIDTH-1:0]   a,
  input  logic [DATA_WIDTH-1:0]   b,
  output logic [DATA_WIDTH-1:0]   result,
  output logic                    illegal
);

  // Decode the operation; anything outside the four defined codes is illegal
  always_comb begin
    result  = '0;
    illegal = 1'b0;
    case (op)
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/exec_writeback_unit.sv
// rtl/exec_writeback_unit.sv - one-in-flight execute/load/write-back unit; optional trap via EXEC_ILLEGAL_OP_TRAP_EN
module exec_writeback_unit
  import exec_writeback_unit_pkg::*;
#(
  parameter int DATA_WIDTH     = 64,
  parameter int REG_ADDR_WIDTH = 5
) (
  input logic                  clk,
  input logic                  rst,
  exec_writeback_unit_if.slave bus
);

`ifdef EXEC_ILLEGAL_OP_TRAP_EN
  localparam logic TRAP_EN = 1'b1;
`else
  localparam logic TRAP_EN = 1'b0;
`endif

  Exec_State_t               state_q;
  Exec_State_t               state_d;

  // Instruction captured at acceptance; stable until the next acceptance
  Exec_Ctrl_t                ctrl_q;
  logic [REG_ADDR_WIDTH-1:0] rd_q;
  logic [DATA_WIDTH-1:0]     rs1_q;
  logic [DATA_WIDTH-1:0]     rs2_q;
  logic [DATA_WIDTH-1:0]     imm_q;

  // Registered results that drive the outputs and hold between valid cycles
  logic [DATA_WIDTH-1:0]     mem_addr_q;
  logic [DATA_WIDTH-1:0]     wb_data_q;
  logic [REG_ADDR_WIDTH-1:0] wb_rd_q;
  logic                      wb_we_q;

  logic [DATA_WIDTH-1:0]     op_b;
  logic [DATA_WIDTH-1:0]     alu_result;
  logic                      alu_illegal;
  logic                      trap_hit;
  logic                      take_mem;
  logic                      wb_we_calc;

  logic                      in_ready_c;
  logic                      mem_req_valid_c;
  logic                      wb_valid_c;

  assign op_b = (ctrl_q.alu_src == ALU_SRC_IMM) ? imm_q : rs2_q;

  alu_core #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_alu_core (
    .op     (ctrl_q.alu_op),
    .a      (rs1_q),
    .b      (op_b),
    .result (alu_result),
    .illegal(alu_illegal)
  );

  // Captured operands do not change until the next acceptance, so the ALU
  // output is still valid in WB and can qualify the trap pulse directly.
  assign trap_hit   = TRAP_EN & alu_illegal;
  assign take_mem   = (ctrl_q.reg_src == REG_SRC_MEM) && !trap_hit;
  assign wb_we_calc = ctrl_q.reg_write && (rd_q != '0) && !trap_hit;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and handshake outputs
  always_comb begin
    state_d         = state_q;
    in_ready_c      = 1'b0;
    mem_req_valid_c = 1'b0;
    wb_valid_c      = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        state_d = take_mem ? MREQ : WB;
      end
      MREQ: begin
        mem_req_valid_c = 1'b1;
        if (bus.mem_req_ready) begin
          state_d = MWAIT;
        end
      end
      MWAIT: begin
        if (bus.mem_rsp_valid) begin
          state_d = WB;
        end
      end
      WB: begin
        wb_valid_c = 1'b1;
        state_d    = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Capture the instruction, register the ALU result and load data
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q     <= '0;
      rd_q       <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      imm_q      <= '0;
      mem_addr_q <= '0;
      wb_data_q  <= '0;
      wb_rd_q    <= '0;
      wb_we_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            ctrl_q <= {bus.alu_op, bus.alu_src, bus.reg_src, bus.reg_write};
            rd_q   <= bus.rd_addr;
            rs1_q  <= bus.rs1_data;
            rs2_q  <= bus.rs2_data;
            imm_q  <= bus.imm;
          end
        end
        EXEC: begin
          if (take_mem) begin
            mem_addr_q <= alu_result;
          end else begin
            wb_data_q <= alu_result;
            wb_rd_q   <= rd_q;
            wb_we_q   <= wb_we_calc;
          end
        end
        MWAIT: begin
          if (bus.mem_rsp_valid) begin
            wb_data_q <= bus.mem_rsp_data;
            wb_rd_q   <= rd_q;
            wb_we_q   <= wb_we_calc;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.in_ready      = in_ready_c;
  assign bus.mem_req_valid = mem_req_valid_c;
  assign bus.mem_addr      = mem_addr_q;
  assign bus.wb_valid      = wb_valid_c;
  assign bus.wb_we         = wb_we_q;
  assign bus.wb_rd         = wb_rd_q;
  assign bus.wb_data       = wb_data_q;
`ifdef EXEC_ILLEGAL_OP_TRAP_EN
  assign bus.illegal_op    = wb_valid_c & alu_illegal;
`endif

endmodule

// File: tb/tb_exec_writeback_unit.sv
// tb/tb_exec_writeback_unit.sv - randomized self-checking bench for exec_writeback_unit
module tb_exec_writeback_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  exec_writeback_unit_if #(.DATA_WIDTH(64), .REG_ADDR_WIDTH(5)) bus ();

  exec_writeback_unit #(
    .DATA_WIDTH    (64),
    .REG_ADDR_WIDTH(5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

`ifdef EXEC_ILLEGAL_OP_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  int cyc = 0;
  logic rst_q = 1'b1;
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
  end

  int errors = 0;
  int checks = 0;

  // Expected timeline of the instruction in flight, in absolute cycles
  int busy_lo = -1, busy_hi = -1, mreq_lo = -1, mreq_hi = -1, wb_cyc = -1;
  logic [63:0] pend_addr = '0, pend_data = '0;
  logic        pend_we = 1'b0, pend_ill = 1'b0;
  logic [4:0]  pend_rd = '0;
  logic [63:0] held_addr = '0, held_data = '0;
  logic        held_we = 1'b0;
  logic [4:0]  held_rd = '0;
  bit          mon_en = 1'b0;
  int          acc_cyc = 0, last_wb_cyc = -1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [63:0] model_alu(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    case (op)
      4'h7:    return a + b;
      4'h0:    return a - b;
      4'h1:    return a & b;
      4'h3:    return a | b;
      default: return 64'd0;
    endcase
  endfunction

  function automatic bit op_defined(input logic [3:0] op);
    return (op == 4'h7) || (op == 4'h0) || (op == 4'h1) || (op == 4'h3);
  endfunction

  // Compare every output against the expected timeline each cycle
  always @(negedge clk) begin
    if (mon_en) begin
      if (rst_q) begin
        held_addr = '0;
        held_data = '0;
        held_we   = 1'b0;
        held_rd   = '0;
      end
      if (cyc == mreq_lo) held_addr = pend_addr;
      if (cyc == wb_cyc) begin
        held_data = pend_data;
        held_we   = pend_we;
        held_rd   = pend_rd;
      end
      check("in_ready", bus.in_ready, !(cyc >= busy_lo && cyc <= busy_hi));
      check("mem_req_valid", bus.mem_req_valid, (cyc >= mreq_lo && cyc <= mreq_hi));
      check("mem_addr", bus.mem_addr, held_addr);
      check("wb_valid", bus.wb_valid, (cyc == wb_cyc));
      check("wb_data", bus.wb_data, held_data);
      check("wb_we", bus.wb_we, held_we);
      check("wb_rd", bus.wb_rd, held_rd);
`ifdef EXEC_ILLEGAL_OP_TRAP_EN
      check("illegal_op", bus.illegal_op, (cyc == wb_cyc) && pend_ill);
`endif
      if (bus.wb_valid === 1'b1) last_wb_cyc = cyc;
    end
  end

  task automatic scramble_inputs();
    bus.alu_op    = 4'($urandom);
    bus.alu_src   = 1'($urandom);
    bus.reg_src   = 1'($urandom);
    bus.reg_write = 1'($urandom);
    bus.rd_addr   = 5'($urandom);
    bus.rs1_data  = {$urandom, $urandom};
    bus.rs2_data  = {$urandom, $urandom};
    bus.imm       = {$urandom, $urandom};
  endtask

  task automatic stale_rsp();
    bus.mem_rsp_valid = 1'($urandom);
    bus.mem_rsp_data  = {$urandom, $urandom};
  endtask

  // Issue one instruction and play the memory side; abort resets in MWAIT
  task automatic do_instr(input logic [3:0] op, input logic src, input logic rsrc, input logic wr,
                          input logic [4:0] rd, input logic [63:0] a, input logic [63:0] b2,
                          input logic [63:0] im, input logic [63:0] md,
                          input int stall, input int lat, input bit abort);
    logic [63:0] res;
    bit trap, is_load;
    int w, n, ml, mh;
    w = 0;
    while (bus.in_ready !== 1'b1 && w < 20) begin
      @(negedge clk);
      stale_rsp();
      w++;
    end
    if (w >= 20) check("ready_timeout", 64'd0, 64'd1);
    res     = model_alu(op, a, src ? im : b2);
    trap    = TRAP && !op_defined(op);
    is_load = (rsrc == 1'b0) && !trap;
    n       = cyc;
    acc_cyc = n;
    ml      = is_load ? n + 2 : -1;
    mh      = is_load ? n + 2 + stall : -1;
    pend_addr = res;
    pend_data = is_load ? md : res;
    pend_we   = wr && (rd != 5'd0) && !trap;
    pend_rd   = rd;
    pend_ill  = trap;
    mreq_lo   = ml;
    mreq_hi   = mh;
    wb_cyc    = is_load ? mh + 1 + lat : n + 2;
    busy_lo   = n + 1;
    busy_hi   = wb_cyc;
    bus.in_valid  = 1'b1;
    bus.alu_op    = op;
    bus.alu_src   = src;
    bus.reg_src   = rsrc;
    bus.reg_write = wr;
    bus.rd_addr   = rd;
    bus.rs1_data  = a;
    bus.rs2_data  = b2;
    bus.imm       = im;
    bus.mem_req_ready = 1'($urandom);
    stale_rsp();
    for (int k = 0; k < 40; k++) begin
      int c;
      @(negedge clk);
      c = cyc;
      bus.in_valid = 1'b0;
      scramble_inputs();
      if (abort && c == mh + 1) begin
        rst = 1'b1;
        busy_hi = c;
        wb_cyc  = -1;
        mreq_lo = -1;
        mreq_hi = -1;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_req_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        break;
      end
      if (is_load && c >= ml && c <= mh) bus.mem_req_ready = (c == mh);
      else bus.mem_req_ready = 1'($urandom);
      if (is_load && c >= mh) begin
        bus.mem_rsp_valid = (c == wb_cyc - 1);
        bus.mem_rsp_data  = (c == wb_cyc - 1) ? md : {$urandom, $urandom};
      end else begin
        stale_rsp();
      end
      if (c >= wb_cyc) break;
    end
  endtask

  initial begin
    int acc_and;
    bus.in_valid = 1'b0;
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_data = '0;
    scramble_inputs();
    repeat (3) @(negedge clk);
    mon_en = 1'b1;
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_wb_valid", bus.wb_valid, 0);
    check("rst_mem_req_valid", bus.mem_req_valid, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_wb_data", bus.wb_data, 0);
    check("rst_wb_we", bus.wb_we, 0);
    check("rst_wb_rd", bus.wb_rd, 0);
    rst = 1'b0;

    check("model_add", model_alu(4'h7, 64'd5, 64'hFFFF_FFFF_FFFF_FFFD), 64'd2);
    check("model_undef", model_alu(4'h5, 64'd9, 64'd9), 64'd0);

    // ADD immediate
    do_instr(4'h7, 1'b1, 1'b1, 1'b1, 5'd3, 64'd5, 64'd77, 64'hFFFF_FFFF_FFFF_FFFD, 64'd0, 0, 1, 1'b0);
    check("add_data", bus.wb_data, 64'd2);
    check("add_we", bus.wb_we, 1);
    check("add_rd", bus.wb_rd, 3);
    #1 check("add_latency", 64'(last_wb_cyc - acc_cyc), 64'd2);

    // SUB wrap, then to rd 0
    do_instr(4'h0, 1'b0, 1'b1, 1'b1, 5'd6, 64'd0, 64'd1, 64'd50, 64'd0, 0, 1, 1'b0);
    check("sub_data", bus.wb_data, 64'hFFFF_FFFF_FFFF_FFFF);
    do_instr(4'h0, 1'b0, 1'b1, 1'b1, 5'd0, 64'd0, 64'd1, 64'd50, 64'd0, 0, 1, 1'b0);
    check("sub_rd0_valid", bus.wb_valid, 1);
    check("sub_rd0_we", bus.wb_we, 0);

    // Load, zero wait then back-pressured
    do_instr(4'h7, 1'b1, 1'b0, 1'b1, 5'd9, 64'h100, 64'd0, 64'd8, 64'h1234, 0, 1, 1'b0);
    #1 check("load_latency", 64'(last_wb_cyc - acc_cyc), 64'd4);
    do_instr(4'h7, 1'b1, 1'b0, 1'b1, 5'd9, 64'h100, 64'd0, 64'd8, 64'hDEADBEEF, 3, 1, 1'b0);
    check("load_data", bus.wb_data, 64'hDEADBEEF);
    #1 check("load_stall_latency", 64'(last_wb_cyc - acc_cyc), 64'd7);

    // AND then OR back to back
    do_instr(4'h1, 1'b0, 1'b1, 1'b1, 5'd4, 64'hF0F0, 64'h0FF0, 64'd0, 64'd0, 0, 1, 1'b0);
    check("and_data", bus.wb_data, 64'h00F0);
    acc_and = acc_cyc;
    do_instr(4'h3, 1'b0, 1'b1, 1'b1, 5'd5, 64'hF0F0, 64'h0FF0, 64'd0, 64'd0, 0, 1, 1'b0);
    check("or_data", bus.wb_data, 64'hFFF0);
    check("b2b_spacing", 64'(acc_cyc - acc_and), 64'd3);

    // Reset during MWAIT, then a stale response in IDLE
    do_instr(4'h7, 1'b1, 1'b0, 1'b1, 5'd7, 64'h40, 64'd0, 64'd4, 64'h55, 0, 5, 1'b1);
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = 64'hBAD;
    repeat (2) @(negedge clk);
    bus.mem_rsp_valid = 1'b0;
    check("post_rst_wb_valid", bus.wb_valid, 0);
    check("post_rst_in_ready", bus.in_ready, 1);
    check("post_rst_mem_addr", bus.mem_addr, 0);
    check("post_rst_wb_data", bus.wb_data, 0);
    do_instr(4'h7, 1'b0, 1'b1, 1'b1, 5'd2, 64'd10, 64'd20, 64'd0, 64'd0, 0, 1, 1'b0);
    check("post_rst_add", bus.wb_data, 64'd30);

    // Undefined op
    do_instr(4'h5, 1'b0, 1'b1, 1'b1, 5'd8, 64'd123, 64'd456, 64'd0, 64'd0, 0, 1, 1'b0);
    check("undef_data", bus.wb_data, 64'd0);
    check("undef_we", bus.wb_we, TRAP ? 64'd0 : 64'd1);

    // Randomized traffic
    for (int i = 0; i < 200; i++) begin
      logic [3:0] op;
      logic [63:0] a, b2, im;
      int sel;
      sel = $urandom_range(0, 9);
      case (sel)
        0, 1: op = 4'h7;
        2, 3: op = 4'h0;
        4, 5: op = 4'h1;
        6, 7: op = 4'h3;
        default: op = 4'($urandom);
      endcase
      a  = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 15)) : {$urandom, $urandom};
      b2 = {$urandom, $urandom};
      im = ($urandom_range(0, 1) == 0) ? {{48{1'b1}}, 16'($urandom)} : {$urandom, $urandom};
      do_instr(op, 1'($urandom), 1'($urandom), 1'($urandom),
               ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom),
               a, b2, im, {$urandom, $urandom},
               $urandom_range(0, 3), $urandom_range(1, 3), 1'b0);
    end
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
